id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with integrated data-hazard interlock for the 5-stage pipelined RV32 core. It latches decoded operands, register indices and the control bundle from IF/ID. It feeds the EX stage and the forwarding unit: `id_ex_rs1`, `id_ex_rs2` and the bubble-cleared `id_ex_rd`. The core forwards only from MEM/WB, with no EX/MEM path, so this block inserts one bubble whenever the instruction in ID reads a register written by the instruction currently in EX.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `CTRL_W`, 8, control bundle width: {Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}; RegWrite is bit 0.

Ports:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-low.
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst`  in  1  synchronous active-low reset.
- `hold`  in  1  global freeze (memory busy); register keeps its contents.
- `flush`  in  1  branch taken; squash the instruction entering ID/EX.
- `if_id_valid`  in  1  IF/ID holds a real instruction.
- `if_id_pc`  in  XLEN  PC of ID instruction.
- `if_id_rs1`, `if_id_rs2`, `if_id_rd`  in  5 each  register indices.
- `if_id_rdata1`, `if_id_rdata2`  in  XLEN each  register-file read data.
- `if_id_imm`  in  XLEN  sign-extended immediate.
- `if_id_funct`  in  4  {inst[30], funct3}.
- `if_id_ctrl`  in  CTRL_W  decoded control bundle.
- `id_ex_valid`  out  1  EX holds a real instruction.
- `id_ex_pc`, `id_ex_rdata1`, `id_ex_rdata2`, `id_ex_imm`  out  XLEN each  registered copies.
- `id_ex_rs1`, `id_ex_rs2`, `id_ex_rd`  out  5 each  registered indices.
- `id_ex_funct`  out  4;  `id_ex_ctrl`  out  CTRL_W.
- `stall`  out  1  combinational; freezes PC and IF/ID for one cycle.

## Operation
- Hazard: `haz` = `if_id_valid` & `id_ex_valid` & `id_ex_ctrl[0]` & (`id_ex_rd` != 0) & (`id_ex_rd` == `if_id_rs1` | `id_ex_rd` == `if_id_rs2`).
  - Comparison is conservative: both rs fields are checked regardless of format.
  - The rule applies to load and ALU producers alike.
- `stall` = `haz` & ~`flush`. A squashed instruction never stalls.
- Register update priority on each rising edge:
  1. `rst`=0: all outputs cleared to zero.
  2. `hold`=1: all registers unchanged.
  3. `flush`=1: load a bubble.
  4. `haz`=1: load a bubble.
  5. Otherwise, load all fields from IF/ID; `id_ex_valid` = `if_id_valid`.
- Bubble: `id_ex_valid`=0, `id_ex_ctrl`=0, `id_ex_rd`=0, `id_ex_rs1`/`id_ex_rs2`=0; data fields zeroed.
  - A bubble can therefore never match in the forwarding unit or write the register file.
- An invalid IF/ID entry is loaded with `ctrl` forced to 0.
- One bubble always resolves the hazard: after it the producer reaches WB while the consumer is in EX, and the MEM/WB forward covers it.

## Timing
- All outputs except `stall` are registered; latency from IF/ID to ID/EX is 1 cycle.
- `stall` is combinational from the registered ID/EX fields and the IF/ID inputs, valid in the same cycle.
- Reset value of every registered output is 0. Reset asserted mid-stall clears the bubble state; `stall` is 0 on the next cycle because `id_ex_valid`=0.
- `hold` and `haz` together: registers are frozen and `stall` stays asserted, so IF/ID is also frozen. The hazard is re-evaluated after `hold` drops.
- Back-to-back dependent chain (A→B→C): one bubble between each pair; each stall lasts exactly 1 cycle.

## Configuration
- `HAZARD_STATS_EN` defined: adds outputs `bubble_cnt` (32) and `flush_cnt` (32).
  - Counts increment on clock edges where the bubble was caused by `haz` or by `flush` respectively, and not on `hold` cycles.
  - Counters wrap modulo 2^32 and reset to 0.
- Macro not defined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `core_pkg`: `XLEN`, `CTRL_W`, control-bit index constants (`CTRL_REGWRITE`=0, `CTRL_MEMREAD`=6, etc.), and the bubble control constant (all zero).
- One sub-module: `hazard_detect`, the pure combinational `haz` comparator, so it can be reused by a future EX/MEM-stage interlock.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with valid IF/ID input → all outputs 0 and `stall`=0. First instruction appears 1 cycle after `rst`=1.
- ALU RAW: `add x5` in EX (RegWrite=1) and `sub` with rs1=5 in ID → `stall`=1 for 1 cycle, next `id_ex_valid`=0 and `ctrl`=0, then `sub` loads.
- x0 / no-write: producer with rd=0, or `sw` (RegWrite=0), and consumer rs2 matching → `stall`=0, no bubble.
- Flush wins: `haz`=1 and `flush`=1 in the same cycle → `stall`=0, bubble loaded; with `HAZARD_STATS_EN`, `flush_cnt`+1 and `bubble_cnt` unchanged.
- Hold during hazard: `hold`=1 for 3 cycles while `haz`=1 → ID/EX unchanged and `stall`=1 throughout; after release, exactly one bubble.
- Independent stream of 10 instructions → zero stalls, each field appearing on outputs 1 cycle after input.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants for the 5-stage RV32 core: datapath widths, control
// bundle bit positions and the ID/EX register update action.
package core_pkg;

    localparam int XLEN      = 32;
    localparam int CTRL_W    = 8;
    localparam int REG_IDX_W = 5;

    // Control bundle layout: {Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_ALUOP_LO = 3;
    localparam int CTRL_ALUOP_HI = 4;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_BRANCH   = 7;

    // A bubble carries no side effects: every control bit is clear.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    // What the ID/EX register does on the next rising edge (reset aside).
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_HAZARD = 2'd3
    } idex_act_e;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: pure combinational RAW comparator between a producer
// sitting one stage ahead and the consumer in ID. Kept separate so a later
// EX/MEM interlock can reuse it unchanged.
module hazard_detect
    import core_pkg::*;
(
    input  logic                 i_consumer_valid,
    input  logic                 i_producer_valid,
    input  logic                 i_producer_regwrite,
    input  logic [REG_IDX_W-1:0] i_producer_rd,
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    output logic                 o_haz
);

    logic w_rd_nonzero;
    logic w_rs_match;

    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    assign w_rd_nonzero = (i_producer_rd != '0);
    // Both source fields are compared regardless of instruction format.
    assign w_rs_match   = (i_producer_rd == i_rs1) || (i_producer_rd == i_rs2);

    assign o_haz = i_consumer_valid & i_producer_valid & i_producer_regwrite
                 & w_rd_nonzero & w_rs_match;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with a one-bubble load-use/ALU
// interlock (the core forwards only from MEM/WB).
// Optional build macro HAZARD_STATS_EN adds bubble_cnt / flush_cnt counters.
module id_ex_stage #(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int CTRL_W = core_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              if_id_valid,
    input  logic [XLEN-1:0]   if_id_pc,
    input  logic [4:0]        if_id_rs1,
    input  logic [4:0]        if_id_rs2,
    input  logic [4:0]        if_id_rd,
    input  logic [XLEN-1:0]   if_id_rdata1,
    input  logic [XLEN-1:0]   if_id_rdata2,
    input  logic [XLEN-1:0]   if_id_imm,
    input  logic [3:0]        if_id_funct,
    input  logic [CTRL_W-1:0] if_id_ctrl,
    output logic              id_ex_valid,
    output logic [XLEN-1:0]   id_ex_pc,
    output logic [XLEN-1:0]   id_ex_rdata1,
    output logic [XLEN-1:0]   id_ex_rdata2,
    output logic [XLEN-1:0]   id_ex_imm,
    output logic [4:0]        id_ex_rs1,
    output logic [4:0]        id_ex_rs2,
    output logic [4:0]        id_ex_rd,
    output logic [3:0]        id_ex_funct,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic              stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    import core_pkg::*;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rdata1;
    logic [XLEN-1:0]   r_rdata2;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [3:0]        r_funct;
    logic [CTRL_W-1:0] r_ctrl;

    logic              w_haz;
    idex_act_e         w_act;

    hazard_detect u_hazard_detect (
        .i_consumer_valid    (if_id_valid),
        .i_producer_valid    (r_valid),
        .i_producer_regwrite (r_ctrl[CTRL_REGWRITE]),
        .i_producer_rd       (r_rd),
        .i_rs1               (if_id_rs1),
        .i_rs2               (if_id_rs2),
        .o_haz               (w_haz)
    );

    // A squashed instruction is discarded anyway, so it must not freeze fetch.
    assign stall = w_haz & ~flush;

    // Resolve the update priority: hold, then flush, then hazard, then load.
    always_comb begin
        // NOTE: default assigned first so every path drives w_act and no latch is inferred.
        w_act = ACT_LOAD;
        if (hold) begin
            w_act = ACT_HOLD;
        end else if (flush) begin
            w_act = ACT_FLUSH;
        end else if (w_haz) begin
            w_act = ACT_HAZARD;
        end
    end

    // ID/EX register: reset to zero, freeze, insert a bubble, or load from IF/ID.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears every field, since downstream
        // stages and the forwarding unit read these registers directly.
        if (!rst) begin
            // NOTE: non-blocking assignments so all fields update together at the edge.
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_funct  <= '0;
            r_ctrl   <= CTRL_BUBBLE;
        end else begin
            unique case (w_act)
                ACT_HOLD: begin
                    // Memory busy: every field keeps its value.
                end
                ACT_FLUSH, ACT_HAZARD: begin
                    // Bubble: rd=0 and ctrl=0 so it can neither forward nor write back.
                    r_valid  <= 1'b0;
                    r_pc     <= '0;
                    r_rdata1 <= '0;
                    r_rdata2 <= '0;
                    r_imm    <= '0;
                    r_rs1    <= '0;
                    r_rs2    <= '0;
                    r_rd     <= '0;
                    r_funct  <= '0;
                    r_ctrl   <= CTRL_BUBBLE;
                end
                default: begin
                    r_valid  <= if_id_valid;
                    r_pc     <= if_id_pc;
                    r_rdata1 <= if_id_rdata1;
                    r_rdata2 <= if_id_rdata2;
                    r_imm    <= if_id_imm;
                    r_rs1    <= if_id_rs1;
                    r_rs2    <= if_id_rs2;
                    r_rd     <= if_id_rd;
                    r_funct  <= if_id_funct;
                    // An empty IF/ID slot must not carry live control bits forward.
                    r_ctrl   <= if_id_valid ? if_id_ctrl : CTRL_BUBBLE;
                end
            endcase
        end
    end

    assign id_ex_valid  = r_valid;
    assign id_ex_pc     = r_pc;
    assign id_ex_rdata1 = r_rdata1;
    assign id_ex_rdata2 = r_rdata2;
    assign id_ex_imm    = r_imm;
    assign id_ex_rs1    = r_rs1;
    assign id_ex_rs2    = r_rs2;
    assign id_ex_rd     = r_rd;
    assign id_ex_funct  = r_funct;
    assign id_ex_ctrl   = r_ctrl;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    // Count inserted bubbles by cause; held edges load nothing and count nothing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (w_act == ACT_FLUSH) begin
            r_flush_cnt  <= r_flush_cnt + 32'd1;
        end else if (w_act == ACT_HAZARD) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, RAW interlock, x0/no-write
// producers, flush priority, hold during hazard, invalid entries,
// reset mid-stall, dependent chain and an independent stream.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        flush;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [4:0]  if_id_rs1;
    logic [4:0]  if_id_rs2;
    logic [4:0]  if_id_rd;
    logic [31:0] if_id_rdata1;
    logic [31:0] if_id_rdata2;
    logic [31:0] if_id_imm;
    logic [3:0]  if_id_funct;
    logic [7:0]  if_id_ctrl;
    logic        id_ex_valid;
    logic [31:0] id_ex_pc;
    logic [31:0] id_ex_rdata1;
    logic [31:0] id_ex_rdata2;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rs1;
    logic [4:0]  id_ex_rs2;
    logic [4:0]  id_ex_rd;
    logic [3:0]  id_ex_funct;
    logic [7:0]  id_ex_ctrl;
    logic        stall;
`ifdef HAZARD_STATS_EN
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // ALU op with RegWrite (ALUOp=10), and a store (MemWrite|ALUSrc, no RegWrite).
    localparam logic [7:0] C_ALU = 8'h11;
    localparam logic [7:0] C_SW  = 8'h06;

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .flush        (flush),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_rs1    (if_id_rs1),
        .if_id_rs2    (if_id_rs2),
        .if_id_rd     (if_id_rd),
        .if_id_rdata1 (if_id_rdata1),
        .if_id_rdata2 (if_id_rdata2),
        .if_id_imm    (if_id_imm),
        .if_id_funct  (if_id_funct),
        .if_id_ctrl   (if_id_ctrl),
        .id_ex_valid  (id_ex_valid),
        .id_ex_pc     (id_ex_pc),
        .id_ex_rdata1 (id_ex_rdata1),
        .id_ex_rdata2 (id_ex_rdata2),
        .id_ex_imm    (id_ex_imm),
        .id_ex_rs1    (id_ex_rs1),
        .id_ex_rs2    (id_ex_rs2),
        .id_ex_rd     (id_ex_rd),
        .id_ex_funct  (id_ex_funct),
        .id_ex_ctrl   (id_ex_ctrl),
        .stall        (stall)
`ifdef HAZARD_STATS_EN
        ,
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction on IF/ID; data fields are derived from the PC.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl);
        if_id_valid  = v;
        if_id_pc     = pc;
        if_id_rs1    = rs1;
        if_id_rs2    = rs2;
        if_id_rd     = rd;
        if_id_rdata1 = pc ^ 32'hA5A5_0000;
        if_id_rdata2 = pc ^ 32'h5A5A_0000;
        if_id_imm    = pc | 32'hFFFF_F000;
        if_id_funct  = rd[3:0] ^ 4'h9;
    if_id_ctrl   = ctrl;
    endtask

    // Compare every registered output with an instruction loaded from IF/ID.
    task automatic expect_load(input string tag, input logic v, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [7:0] ctrl);
        logic [3:0] fn;
        fn = rd[3:0] ^ 4'h9;
        check({tag, ".valid"}, {31'd0, id_ex_valid}, {31'd0, v});
        check({tag, ".pc"},    id_ex_pc, pc);
        check({tag, ".rd1"},   id_ex_rdata1, pc ^ 32'hA5A5_0000);
        check({tag, ".rd2"},   id_ex_rdata2, pc ^ 32'h5A5A_0000);
        check({tag, ".imm"},   id_ex_imm, pc | 32'hFFFF_F000);
        check({tag, ".rs1"},   {27'd0, id_ex_rs1}, {27'd0, rs1});
        check({tag, ".rs2"},   {27'd0, id_ex_rs2}, {27'd0, rs2});
        check({tag, ".rd"},    {27'd0, id_ex_rd}, {27'd0, rd});
        check({tag, ".funct"}, {28'd0, id_ex_funct}, {28'd0, fn});
        check({tag, ".ctrl"},  {24'd0, id_ex_ctrl}, {24'd0, ctrl});
    endtask

    // Compare every registered output with an all-zero bubble.
    task automatic expect_bubble(input string tag);
        check({tag, ".valid"}, {31'd0, id_ex_valid}, 32'd0);
        check({tag, ".pc"},    id_ex_pc, 32'd0);
        check({tag, ".rd1"},   id_ex_rdata1, 32'd0);
        check({tag, ".rd2"},   id_ex_rdata2, 32'd0);
        check({tag, ".imm"},   id_ex_imm, 32'd0);
        check({tag, ".rs1"},   {27'd0, id_ex_rs1}, 32'd0);
        check({tag, ".rs2"},   {27'd0, id_ex_rs2}, 32'd0);
        check({tag, ".rd"},    {27'd0, id_ex_rd}, 32'd0);
        check({tag, ".funct"}, {28'd0, id_ex_funct}, 32'd0);
        check({tag, ".ctrl"},  {24'd0, id_ex_ctrl}, 32'd0);
    endtask

    task automatic check_stall(input string tag, input logic exp);
        #1;
        check(tag, {31'd0, stall}, {31'd0, exp});
    endtask

    initial begin
        rst   = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        drive(1'b1, 32'h0000_0100, 5'd1, 5'd2, 5'd5, C_ALU);

        // Reset held two cycles with a valid instruction waiting.
        tick();
        tick();
        expect_bubble("reset");
        check_stall("reset.stall", 1'b0);

        // A: add x5, x1, x2 appears one cycle after reset release.
        rst = 1'b1;
        tick();
        expect_load("A", 1'b1, 32'h0000_0100, 5'd1, 5'd2, 5'd5, C_ALU);

        // B: sub x6, x5, x3 depends on A -> one stall cycle, one bubble.
        drive(1'b1, 32'h0000_0104, 5'd5, 5'd3, 5'd6, C_ALU);
        check_stall("raw.stall", 1'b1);
        tick();
        expect_bubble("raw.bubble");
        check_stall("raw.stall_clear", 1'b0);
        tick();
        expect_load("B", 1'b1, 32'h0000_0104, 5'd5, 5'd3, 5'd6, C_ALU);

        // C writes x0; D reads x0 through rs2 -> no interlock.
        drive(1'b1, 32'h0000_0108, 5'd7, 5'd8, 5'd0, C_ALU);
        check_stall("c.stall", 1'b0);
        tick();
        expect_load("C", 1'b1, 32'h0000_0108, 5'd7, 5'd8, 5'd0, C_ALU);
        drive(1'b1, 32'h0000_010C, 5'd9, 5'd0, 5'd4, C_SW);
        check_stall("x0.stall", 1'b0);
        tick();
        expect_load("D", 1'b1, 32'h0000_010C, 5'd9, 5'd0, 5'd4, C_SW);

        // E's rs2 equals the store's rd field, but a store writes nothing.
        drive(1'b1, 32'h0000_0110, 5'd10, 5'd4, 5'd11, C_ALU);
        check_stall("sw.stall", 1'b0);
        tick();
        expect_load("E", 1'b1, 32'h0000_0110, 5'd10, 5'd4, 5'd11, C_ALU);

        // F depends on E but is flushed in the same cycle: flush wins.
        drive(1'b1, 32'h0000_0114, 5'd11, 5'd1, 5'd12, C_ALU);
        flush = 1'b1;
        check_stall("flush.stall", 1'b0);
        tick();
        flush = 1'b0;
        expect_bubble("flush.bubble");
`ifdef HAZARD_STATS_EN
        check("flush.flush_cnt",  flush_cnt,  32'd1);
        check("flush.bubble_cnt", bubble_cnt, 32'd1);
`endif

        // G: independent producer of x12.
        drive(1'b1, 32'h0000_0200, 5'd1, 5'd2, 5'd12, C_ALU);
        check_stall("g.stall", 1'b0);
        tick();
        expect_load("G", 1'b1, 32'h0000_0200, 5'd1, 5'd2, 5'd12, C_ALU);

        // H depends on G while memory holds the pipe for three cycles.
        drive(1'b1, 32'h0000_0204, 5'd12, 5'd3, 5'd13, C_ALU);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_stall($sformatf("hold%0d.stall", i), 1'b1);
            tick();
            check($sformatf("hold%0d.pc", i), id_ex_pc, 32'h0000_0200);
            check($sformatf("hold%0d.rd", i), {27'd0, id_ex_rd}, 32'd12);
        end
        hold = 1'b0;
        check_stall("hold.release_stall", 1'b1);
        tick();
        expect_bubble("hold.bubble");
        check_stall("hold.after_stall", 1'b0);
        tick();
        expect_load("H", 1'b1, 32'h0000_0204, 5'd12, 5'd3, 5'd13, C_ALU);
`ifdef HAZARD_STATS_EN
        check("hold.bubble_cnt", bubble_cnt, 32'd2);
        check("hold.flush_cnt",  flush_cnt,  32'd1);
`endif

        // Invalid IF/ID entry with live control bits: ctrl forced to zero.
        drive(1'b0, 32'h0000_0300, 5'd13, 5'd13, 5'd14, C_ALU);
        check_stall("inv.stall", 1'b0);
        tick();
        expect_load("INV", 1'b0, 32'h0000_0300, 5'd13, 5'd13, 5'd14, 8'h00);

        // Reset while a stall is pending clears everything; stall then drops.
        drive(1'b1, 32'h0000_0400, 5'd1, 5'd2, 5'd15, C_ALU);
        tick();
        expect_load("P", 1'b1, 32'h0000_0400, 5'd1, 5'd2, 5'd15, C_ALU);
        drive(1'b1, 32'h0000_0404, 5'd15, 5'd2, 5'd16, C_ALU);
        check_stall("rststall.pre", 1'b1);
        rst = 1'b0;
        tick();
        expect_bubble("rststall");
        check_stall("rststall.post", 1'b0);
`ifdef HAZARD_STATS_EN
        check("rst.bubble_cnt", bubble_cnt, 32'd0);
        check("rst.flush_cnt",  flush_cnt,  32'd0);
`endif
        rst = 1'b1;

        // Dependent chain I1 -> I2 -> I3: one single-cycle stall per link.
        drive(1'b1, 32'h0000_0500, 5'd1, 5'd2, 5'd14, C_ALU);
        tick();
        expect_load("I1", 1'b1, 32'h0000_0500, 5'd1, 5'd2, 5'd14, C_ALU);
        drive(1'b1, 32'h0000_0504, 5'd14, 5'd2, 5'd15, C_ALU);
        check_stall("chain2.stall", 1'b1);
        tick();
        check("chain2.bubble", {31'd0, id_ex_valid}, 32'd0);
        check_stall("chain2.clear", 1'b0);
        tick();
        expect_load("I2", 1'b1, 32'h0000_0504, 5'd14, 5'd2, 5'd15, C_ALU);
        drive(1'b1, 32'h0000_0508, 5'd3, 5'd15, 5'd16, C_ALU);
        check_stall("chain3.stall", 1'b1);
        tick();
        check("chain3.bubble", {31'd0, id_ex_valid}, 32'd0);
        check_stall("chain3.clear", 1'b0);
        tick();
        expect_load("I3", 1'b1, 32'h0000_0508, 5'd3, 5'd15, 5'd16, C_ALU);
`ifdef HAZARD_STATS_EN
        check("chain.bubble_cnt", bubble_cnt, 32'd2);
        check("chain.flush_cnt",  flush_cnt,  32'd0);
`endif

        // Ten independent instructions: no stalls, one-cycle latency each.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] pc;
            logic [4:0]  rd;
            pc = 32'h0000_0600 + 32'(i * 4);
            rd = 5'(17 + i);
            drive(1'b1, pc, 5'd1, 5'd2, rd, C_ALU);
            check_stall($sformatf("ind%0d.stall", i), 1'b0);
            tick();
            expect_load($sformatf("ind%0d", i), 1'b1, pc, 5'd1, 5'd2, rd, C_ALU);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
